pipe_stall_ctrl: RTL and testbench
==================================

// Module: pipe_stall_ctrl
// PURPOSE
//  Central stall/bubble controller for the 5-stage pipeline. Detects D-stage RAW hazards from Tuse/Tnew
//  against the E and M stages, ERET-vs-EPC-write hazards, and HI/LO contention with the iterative
//  mult/div unit. Drives PC/D-register enables and the E-register bubble (flush) input.
//  Owns the mult/div busy counter and a saturating stall-cycle counter.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles after a mult/multu starts in E
//  DIV_CYCLES   10  busy cycles after a div/divu starts in E
//  CNT_W        32  width of stall_cnt
// PORTS
//  clk          in   1   pipeline clock
//  reset        in   1   synchronous, active-high
//  Req          in   1   exception/interrupt request (M stage); pipeline registers self-clear on it
//  rs_D, rt_D   in   5   D-stage source register numbers
//  tuse_rs_D    in   2   cycles until rs needed (3 = not used)
//  tuse_rt_D    in   2   cycles until rt needed (3 = not used)
//  a_E, a_M     in   5   destination register of E / M instruction (0 = none)
//  tnew_E       in   2   cycles until E result available
//  tnew_M       in   2   cycles until M result available
//  md_use_D     in   1   D instr is mult/div/mfhi/mflo/mthi/mtlo
//  md_start_E   in   1   E instr is mult/multu/div/divu (one cycle per instr)
//  md_div_E     in   1   with md_start_E: 1 = div/divu, 0 = mult/multu
//  eret_D       in   1   D instr is eret
//  epc_wr_E     in   1   E instr is mtc0 to EPC (rd=14)
//  epc_wr_M     in   1   M instr is mtc0 to EPC
//  en_PC        out  1   PC register enable
//  en_D         out  1   D register enable
//  flush_E      out  1   bubble into E register
//  md_busy      out  1   mult/div unit busy (to E stage, HI/LO mux)
//  stall        out  1   hazard stall this cycle
//  stall_cnt    out  CNT_W  total stall cycles since reset, saturating
// BEHAVIOUR
//  Reset (sync, priority over all): state=IDLE, md_cnt=0, stall_cnt=0; while reset high outputs forced
//   en_PC=1, en_D=1, flush_E=0, stall=0, md_busy=0.
//  RAW: stall_rs = rs_D!=0 & ((rs_D==a_E & tnew_E>tuse_rs_D) | (rs_D==a_M & tnew_M>tuse_rs_D)); same
//   for rt. a_E/a_M==0 never matches.
//  ERET: stall_eret = eret_D & (epc_wr_E | epc_wr_M).
//  MD: stall_md = md_use_D & (md_start_E | md_busy).
//  stall = (stall_rs|stall_rt|stall_eret|stall_md) & ~Req. Combinational, same-cycle.
//  stall=1 -> en_PC=0, en_D=0, flush_E=1. stall=0 -> en_PC=1, en_D=1, flush_E=0.
//  Req=1: stall forced 0 (enables 1, flush_E 0); EREG/other regs load exception state themselves.
//  MD FSM (md_cnt width >= clog2(DIV_CYCLES+1)):
//   IDLE: md_start_E & ~Req -> BUSY, md_cnt <= (md_div_E ? DIV_CYCLES : MULT_CYCLES).
//   BUSY: md_cnt <= md_cnt-1 each cycle; md_cnt==1 -> IDLE, md_cnt<=0.
//   md_busy = (state==BUSY), registered; first high cycle is the one after md_start_E.
//   md_start_E in BUSY cannot occur (stalled in D); if seen, ignored (no restart).
//   Req with md_start_E same cycle: E instr is cancelled, no start. Req while BUSY: operation
//   continues to completion (HI/LO committed), counter not cleared.
//  stall_cnt: +1 on each clock with stall=1; holds at all-ones.
//  Latency: hazard->stall 0 cycles; md_start_E->md_busy 1 cycle; busy lasts exactly N cycles.
// TESTING
//  lw $1 in E (a_E=1,tnew_E=2), D addu rs=1 tuse=1 -> stall=1, en_PC=0, en_D=0, flush_E=1.
//  rs_D=0, a_E=0, tnew_E=2, tuse=0 -> stall=0 (zero register never hazards).
//  mult in E (md_start_E=1,md_div_E=0) then mflo held in D -> stall 6 cycles (1 start + 5 busy),
//   md_busy high cycles 2..6, mflo proceeds cycle 7; stall_cnt=6.
//  div start, Req at busy cycle 3 -> stall forced 0 that cycle, md_busy stays high total 10 cycles.
//  eret_D with epc_wr_M=1 -> stall=1; next cycle epc_wr_M=0 -> stall=0.
//  reset asserted mid-BUSY (cnt=4) -> next edge md_busy=0, stall_cnt=0, en_PC=1.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Central stall/bubble controller: RAW, ERET-vs-EPC and HI/LO hazards, the mult/div
// busy sequencer and a saturating stall-cycle counter.
module pipe_stall_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Req,
   input  logic [4:0]       rs_D,
   input  logic [4:0]       rt_D,
   input  logic [1:0]       tuse_rs_D,
   input  logic [1:0]       tuse_rt_D,
   input  logic [4:0]       a_E,
   input  logic [4:0]       a_M,
   input  logic [1:0]       tnew_E,
   input  logic [1:0]       tnew_M,
   input  logic             md_use_D,
   input  logic             md_start_E,
   input  logic             md_div_E,
   input  logic             eret_D,
   input  logic             epc_wr_E,
   input  logic             epc_wr_M,
   output logic             en_PC,
   output logic             en_D,
   output logic             flush_E,
   output logic             md_busy,
   output logic             stall,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int MAX_CYC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int MD_W    = $clog2(MAX_CYC + 1);

   typedef enum logic {IDLE, BUSY} md_state_t;

   md_state_t       state, state_nxt;
   logic [MD_W-1:0] md_cnt, md_cnt_nxt;
   logic            stall_rs, stall_rt, stall_eret, stall_md;

   // Register 0 is hardwired, so neither a source nor a destination of 0 can hazard.
   assign stall_rs = (rs_D != 5'd0) &
                     (((rs_D == a_E) & (tnew_E > tuse_rs_D)) |
                      ((rs_D == a_M) & (tnew_M > tuse_rs_D)));
   assign stall_rt = (rt_D != 5'd0) &
                     (((rt_D == a_E) & (tnew_E > tuse_rt_D)) |
                      ((rt_D == a_M) & (tnew_M > tuse_rt_D)));
   assign stall_eret = eret_D & (epc_wr_E | epc_wr_M);
   assign stall_md   = md_use_D & (md_start_E | md_busy);

   assign md_busy = (state == BUSY) & ~reset;
   assign stall   = (stall_rs | stall_rt | stall_eret | stall_md) & ~Req & ~reset;
   assign en_PC   = ~stall;
   assign en_D    = ~stall;
   assign flush_E = stall;

   // A start seen while busy is ignored; Req cancels a start but not a running op.
   always_comb begin
      state_nxt  = state;
      md_cnt_nxt = md_cnt;
      unique case (state)
         IDLE: if (md_start_E && !Req) begin
            state_nxt  = BUSY;
            md_cnt_nxt = md_div_E ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);
         end
         BUSY: if (md_cnt == MD_W'(1)) begin
            state_nxt  = IDLE;
            md_cnt_nxt = '0;
         end else begin
            md_cnt_nxt = md_cnt - MD_W'(1);
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         md_cnt    <= '0;
         stall_cnt <= '0;
      end else begin
         state  <= state_nxt;
         md_cnt <= md_cnt_nxt;
         if (stall && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: a driver pushes reference-model expectations,
// a negedge monitor pops and compares. Narrow counter so saturation is reachable.
module tb_pipe_stall_ctrl;

   localparam int MULT_C = 5;
   localparam int DIV_C  = 10;
   localparam int CW     = 4;

   typedef struct {
      logic       reset, Req;
      logic [4:0] rs, rt, a_E, a_M;
      logic [1:0] tuse_rs, tuse_rt, tnew_E, tnew_M;
      logic       md_use, md_start, md_div, eret, epc_wr_E, epc_wr_M;
   } stim_t;

   // {en_PC, en_D, flush_E, md_busy, stall, stall_cnt}
   typedef logic [CW+4:0] resp_t;

   logic          clk = 1'b0;
   logic          reset, Req, md_use_D, md_start_E, md_div_E, eret_D, epc_wr_E, epc_wr_M;
   logic [4:0]    rs_D, rt_D, a_E, a_M;
   logic [1:0]    tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
   logic          en_PC, en_D, flush_E, md_busy, stall;
   logic [CW-1:0] stall_cnt;

   int    checks = 0;
   int    failures = 0;
   resp_t sb[$];

   // reference model state
   int    busy_left = 0;
   int    stall_total = 0;
   stim_t cur;
   bit    cur_stall = 0;

   always #5 clk = ~clk;

   pipe_stall_ctrl #(.MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .Req(Req), .rs_D(rs_D), .rt_D(rt_D),
      .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D), .a_E(a_E), .a_M(a_M),
      .tnew_E(tnew_E), .tnew_M(tnew_M), .md_use_D(md_use_D), .md_start_E(md_start_E),
      .md_div_E(md_div_E), .eret_D(eret_D), .epc_wr_E(epc_wr_E), .epc_wr_M(epc_wr_M),
      .en_PC(en_PC), .en_D(en_D), .flush_E(flush_E), .md_busy(md_busy), .stall(stall),
      .stall_cnt(stall_cnt));

   function automatic stim_t idle_s();
      stim_t s;
      s = '{reset: 1'b0, Req: 1'b0, rs: 5'd0, rt: 5'd0, a_E: 5'd0, a_M: 5'd0,
            tuse_rs: 2'd3, tuse_rt: 2'd3, tnew_E: 2'd0, tnew_M: 2'd0,
            md_use: 1'b0, md_start: 1'b0, md_div: 1'b0, eret: 1'b0,
            epc_wr_E: 1'b0, epc_wr_M: 1'b0};
      return s;
   endfunction

   // A source is late if any in-flight producer of it delivers after it is needed.
   function automatic bit raw(input logic [4:0] src, input logic [1:0] tuse, input stim_t s);
      int need, ready_E, ready_M;
      need = int'(tuse); ready_E = int'(s.tnew_E); ready_M = int'(s.tnew_M);
      if (src == 5'd0) return 0;
      if (src == s.a_E && ready_E > need) return 1;
      if (src == s.a_M && ready_M > need) return 1;
      return 0;
   endfunction

   task automatic step(input stim_t s);
      bit    st, busy;
      resp_t e;
      @(posedge clk);
      // advance the model across the edge using the previous cycle's inputs
      if (cur.reset) begin
         busy_left = 0; stall_total = 0;
      end else begin
         if (cur_stall && stall_total < (1 << CW) - 1) stall_total++;
         if (busy_left > 0) busy_left--;
         else if (cur.md_start && !cur.Req) busy_left = cur.md_div ? DIV_C : MULT_C;
      end
      #1;
      reset = s.reset; Req = s.Req; rs_D = s.rs; rt_D = s.rt; a_E = s.a_E; a_M = s.a_M;
      tuse_rs_D = s.tuse_rs; tuse_rt_D = s.tuse_rt; tnew_E = s.tnew_E; tnew_M = s.tnew_M;
      md_use_D = s.md_use; md_start_E = s.md_start; md_div_E = s.md_div; eret_D = s.eret;
      epc_wr_E = s.epc_wr_E; epc_wr_M = s.epc_wr_M;
      busy = !s.reset && busy_left > 0;
      st = !s.reset && !s.Req &&
           (raw(s.rs, s.tuse_rs, s) || raw(s.rt, s.tuse_rt, s) ||
            (s.eret && (s.epc_wr_E || s.epc_wr_M)) ||
            (s.md_use && (s.md_start || busy)));
      e = {~st, ~st, st, busy, st, CW'(stall_total)};
      sb.push_back(e);
      cur = s; cur_stall = st;
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         resp_t e, a;
         e = sb.pop_front();
         a = {en_PC, en_D, flush_E, md_busy, stall, stall_cnt};
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL outputs t=%0t {en_PC,en_D,flush_E,md_busy,stall,cnt} actual=%b_%0d required=%b_%0d",
                     $time, a[CW+4:CW], a[CW-1:0], e[CW+4:CW], e[CW-1:0]);
         end
      end
   end

   initial begin
      stim_t s;
      cur = idle_s(); cur.reset = 1'b1;
      s = cur;
      reset = 1'b1; Req = 1'b0; rs_D = '0; rt_D = '0; a_E = '0; a_M = '0;
      tuse_rs_D = 2'd3; tuse_rt_D = 2'd3; tnew_E = '0; tnew_M = '0; md_use_D = 1'b0;
      md_start_E = 1'b0; md_div_E = 1'b0; eret_D = 1'b0; epc_wr_E = 1'b0; epc_wr_M = 1'b0;
      repeat (3) step(s);

      // load-use on rs, then zero register never hazards
      s = idle_s(); s.a_E = 5'd1; s.tnew_E = 2'd2; s.rs = 5'd1; s.tuse_rs = 2'd1; step(s);
      s = idle_s(); s.tnew_E = 2'd2; s.tuse_rs = 2'd0; step(s);
      s = idle_s(); s.a_M = 5'd7; s.tnew_M = 2'd1; s.rt = 5'd7; s.tuse_rt = 2'd0; step(s);

      // mult in E with mflo held in D: 6 stall cycles, proceeds on the 7th
      s = idle_s(); s.md_start = 1'b1; s.md_use = 1'b1; step(s);
      s = idle_s(); s.md_use = 1'b1; repeat (6) step(s);

      // div with Req during its third busy cycle
      s = idle_s(); s.md_start = 1'b1; s.md_div = 1'b1; s.md_use = 1'b1; step(s);
      s = idle_s(); s.md_use = 1'b1; repeat (2) step(s);
      s.Req = 1'b1; step(s);
      s.Req = 1'b0; repeat (9) step(s);

      // Req cancels a same-cycle start
      s = idle_s(); s.md_start = 1'b1; s.Req = 1'b1; step(s);
      s = idle_s(); s.md_use = 1'b1; step(s);

      // eret vs EPC write in M, then cleared
      s = idle_s(); s.eret = 1'b1; s.epc_wr_M = 1'b1; step(s);
      s.epc_wr_M = 1'b0; step(s);
      s.epc_wr_E = 1'b1; step(s);

      // reset mid-busy
      s = idle_s(); s.md_start = 1'b1; step(s);
      s = idle_s(); s.md_use = 1'b1; repeat (2) step(s);
      s.reset = 1'b1; step(s);
      s.reset = 1'b0; repeat (2) step(s);

      // randomized traffic, small register range to provoke hazards
      repeat (3000) begin
         s.reset    = ($urandom_range(0, 59) == 0);
         s.Req      = ($urandom_range(0, 11) == 0);
         s.rs       = 5'($urandom_range(0, 3));
         s.rt       = 5'($urandom_range(0, 3));
         s.a_E      = 5'($urandom_range(0, 3));
         s.a_M      = 5'($urandom_range(0, 3));
         s.tuse_rs  = 2'($urandom_range(0, 3));
         s.tuse_rt  = 2'($urandom_range(0, 3));
         s.tnew_E   = 2'($urandom_range(0, 3));
         s.tnew_M   = 2'($urandom_range(0, 3));
         s.md_use   = ($urandom_range(0, 3) == 0);
         s.md_start = ($urandom_range(0, 7) == 0);
         s.md_div   = 1'($urandom_range(0, 1));
         s.eret     = ($urandom_range(0, 7) == 0);
         s.epc_wr_E = ($urandom_range(0, 3) == 0);
         s.epc_wr_M = ($urandom_range(0, 3) == 0);
         step(s);
      end

      repeat (2) @(posedge clk);
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
